// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues data-memory requests, stalls upstream until ack, forwards results to WB.
// Optional build macro MEM_TIMEOUT_EN adds an 8-bit ACCESS timeout that aborts a request after 255 idle wait cycles.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  d_rd,
  input  logic [31:0] d_A,
  input  logic [31:0] d_B,
  input  logic [31:0] d_ALUresult,
  input  logic        d_MemtoReg,
  input  logic        d_RegSrc,
  input  logic        d_MemWrite,
  input  logic        d_MemAddrSrc,
  input  logic [2:0]  d_InstrType,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [4:0]  q_rd,
  output logic [31:0] q_result,
  output logic        q_RegSrc,
  output logic [2:0]  q_InstrType,
  output logic        q_valid,
  output logic        q_err,
  output logic        stall
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ITYPE_W = 3;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                mem_op_c, aligned_c, tmo_hit;
  logic [DATA_W-1:0]   addr_c;
  logic                start_c, alu_c, mis_c, done_c, tmo_c, stall_raw;
  logic [REG_W-1:0]    lat_rd;
  logic [DATA_W-1:0]   lat_alu;
  logic                lat_regsrc, lat_load;
  logic [ITYPE_W-1:0]  lat_itype;

  assign mem_op_c  = d_MemtoReg | d_MemWrite;
  assign addr_c    = d_MemAddrSrc ? d_A : d_ALUresult;
  assign aligned_c = (addr_c[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  logic [TMO_W-1:0] tmo_cnt_q;

  // Wait-cycle counter; saturating at all-ones triggers the abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   tmo_cnt_q <= '0;
    else if (start_c)                             tmo_cnt_q <= '0;
    else if (state_q == ACCESS && !dmem_ack && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  assign tmo_hit = (tmo_cnt_q == {TMO_W{1'b1}});
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle action decode
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    alu_c     = 1'b0;
    mis_c     = 1'b0;
    done_c    = 1'b0;
    tmo_c     = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (!mem_op_c) begin
            alu_c = 1'b1;
          end else if (aligned_c) begin
            start_c   = 1'b1;
            stall_raw = 1'b1;
            state_d   = ACCESS;
          end else begin
            mis_c = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_c   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall must drop the instant reset asserts, even with a pending memory op on the inputs
  assign stall = reset & stall_raw;

  // Memory request and WB result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      q_rd        <= '0;
      q_result    <= '0;
      q_RegSrc    <= 1'b0;
      q_InstrType <= '0;
      q_valid     <= 1'b0;
      q_err       <= 1'b0;
      lat_rd      <= '0;
      lat_alu     <= '0;
      lat_regsrc  <= 1'b0;
      lat_itype   <= '0;
      lat_load    <= 1'b0;
    end else begin
      if (alu_c) begin
        q_result    <= d_ALUresult;
        q_rd        <= d_rd;
        q_RegSrc    <= d_RegSrc;
        q_InstrType <= d_InstrType;
        q_valid     <= 1'b1;
        q_err       <= 1'b0;
      end
      if (mis_c || tmo_c) begin
        q_result <= '0;
        q_valid  <= 1'b0;
        q_err    <= 1'b1;
      end
      if (start_c) begin
        dmem_req   <= 1'b1;
        dmem_we    <= d_MemWrite;
        dmem_addr  <= addr_c;
        dmem_wdata <= d_B;
        lat_rd     <= d_rd;
        lat_alu    <= d_ALUresult;
        lat_regsrc <= d_RegSrc;
        lat_itype  <= d_InstrType;
        lat_load   <= d_MemtoReg & ~d_MemWrite;
      end
      if (done_c) begin
        q_result    <= lat_load ? dmem_rdata : lat_alu;
        q_rd        <= lat_rd;
        q_RegSrc    <= lat_regsrc;
        q_InstrType <= lat_itype;
        q_valid     <= 1'b1;
        q_err       <= 1'b0;
      end
      if (done_c || tmo_c) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a transaction-level model of the MEM stage.
// Honours MEM_TIMEOUT_EN the same way as the design.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  d_rd;
  logic [31:0] d_A, d_B, d_ALUresult;
  logic        d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc;
  logic [2:0]  d_InstrType;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [4:0]  q_rd;
  logic [31:0] q_result;
  logic        q_RegSrc;
  logic [2:0]  q_InstrType;
  logic        q_valid, q_err, stall;

  int n_checks = 0;
  int n_errors = 0;

  // Expected WB-side state
  logic [4:0]  exp_rd;
  logic [31:0] exp_result;
  logic        exp_regsrc, exp_valid, exp_err;
  logic [2:0]  exp_itype;

  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .d_rd(d_rd), .d_A(d_A), .d_B(d_B),
    .d_ALUresult(d_ALUresult), .d_MemtoReg(d_MemtoReg), .d_RegSrc(d_RegSrc),
    .d_MemWrite(d_MemWrite), .d_MemAddrSrc(d_MemAddrSrc), .d_InstrType(d_InstrType),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .q_rd(q_rd), .q_result(q_result),
    .q_RegSrc(q_RegSrc), .q_InstrType(q_InstrType), .q_valid(q_valid), .q_err(q_err),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, ".q_rd"},     32'(q_rd),        32'(exp_rd));
    check({tag, ".q_result"}, q_result,         exp_result);
    check({tag, ".q_RegSrc"}, 32'(q_RegSrc),    32'(exp_regsrc));
    check({tag, ".q_itype"},  32'(q_InstrType), 32'(exp_itype));
    check({tag, ".q_valid"},  32'(q_valid),     32'(exp_valid));
    check({tag, ".q_err"},    32'(q_err),       32'(exp_err));
  endtask

  task automatic model_reset();
    exp_rd = '0; exp_result = '0; exp_regsrc = 1'b0; exp_itype = '0;
    exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  task automatic scramble_inputs();
    en = 1'($urandom); d_rd = 5'($urandom); d_A = $urandom; d_B = $urandom;
    d_ALUresult = $urandom; d_MemtoReg = 1'($urandom); d_RegSrc = 1'($urandom);
    d_MemWrite = 1'($urandom); d_MemAddrSrc = 1'($urandom); d_InstrType = 3'($urandom);
  endtask

  // One instruction through the stage; entered and left just after a falling edge
  task automatic run_op(input string tag, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] alu, input logic mtr, input logic rs, input logic mw,
                        input logic src, input logic [2:0] it, input int wait_cyc, input logic [31:0] rdata);
    logic [31:0] addr;
    addr = src ? a : alu;
    en = 1'b1; d_rd = rd; d_A = a; d_B = b; d_ALUresult = alu; d_MemtoReg = mtr;
    d_RegSrc = rs; d_MemWrite = mw; d_MemAddrSrc = src; d_InstrType = it; dmem_ack = 1'b0;
    #1;
    if (!(mtr || mw)) begin
      check({tag, ".alu_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      exp_rd = rd; exp_result = alu; exp_regsrc = rs; exp_itype = it; exp_valid = 1'b1; exp_err = 1'b0;
      check_q({tag, ".alu"});
      check({tag, ".alu_req"}, 32'(dmem_req), 32'd0);
    end else if (addr[1:0] != 2'b00) begin
      check({tag, ".mis_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      exp_result = '0; exp_valid = 1'b0; exp_err = 1'b1;
      check_q({tag, ".mis"});
      check({tag, ".mis_req"}, 32'(dmem_req), 32'd0);
    end else begin
      check({tag, ".issue_stall"}, 32'(stall), 32'd1);
      check({tag, ".issue_req"}, 32'(dmem_req), 32'd0);
      @(negedge clk);
      for (int i = 0; i <= wait_cyc; i++) begin
        scramble_inputs();
        check({tag, ".req"},   32'(dmem_req), 32'd1);
        check({tag, ".we"},    32'(dmem_we),  32'(mw));
        check({tag, ".addr"},  dmem_addr,     addr);
        check({tag, ".wdata"}, dmem_wdata,    b);
        check({tag, ".hold_valid"}, 32'(q_valid), 32'(exp_valid));
        if (i == wait_cyc) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
          #1 check({tag, ".ack_stall"}, 32'(stall), 32'd0);
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
          #1 check({tag, ".wait_stall"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      exp_rd = rd; exp_result = (mtr && !mw) ? rdata : alu; exp_regsrc = rs; exp_itype = it;
      exp_valid = 1'b1; exp_err = 1'b0;
      check_q({tag, ".done"});
      check({tag, ".done_req"}, 32'(dmem_req), 32'd0);
    end
  endtask

  // Pipeline disabled for a cycle; a stray ack must be ignored
  task automatic idle_cycle();
    scramble_inputs();
    en = 1'b0; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    check("idle.stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("idle.req", 32'(dmem_req), 32'd0);
    check_q("idle");
    dmem_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] a, alu;
    logic src, mtr, mw;

    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    en = 1'b1; d_rd = 5'd7; d_A = 32'h40; d_B = 32'h1; d_ALUresult = 32'h80;
    d_MemtoReg = 1'b1; d_RegSrc = 1'b1; d_MemWrite = 1'b0; d_MemAddrSrc = 1'b0; d_InstrType = 3'd5;
    model_reset();
    #2;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check_q("rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b1; en = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("alu30", 5'd2, 32'h0, 32'h0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 0, 32'h0);
    run_op("load100", 5'd3, 32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3, 32'hDEADBEEF);
    run_op("store200", 5'd4, 32'h200, 32'd25, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 0, 32'h12345678);
    run_op("load102", 5'd5, 32'h0, 32'h0, 32'h102, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 0, 32'h0);
    run_op("both", 5'd6, 32'h0, 32'h77, 32'h304, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1, 32'hAAAA5555);
    idle_cycle();

    // No-ack behaviour: timeout abort or indefinite wait
    run_op("tmo_pre", 5'd9, 32'h0, 32'h0, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 0, 32'h0);
    en = 1'b1; d_rd = 5'd8; d_ALUresult = 32'h300; d_MemtoReg = 1'b1; d_MemWrite = 1'b0;
    d_MemAddrSrc = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    en = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt = 0;
    while (dmem_req && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo.req_cycles_in_range", 32'(cnt >= 255 && cnt <= 256), 32'd1);
    exp_result = '0; exp_valid = 1'b0; exp_err = 1'b1;
    check_q("tmo");
    #1 check("tmo.stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("tmo.idle_req", 32'(dmem_req), 32'd0);
`else
    cnt = 0;
    repeat (300) @(negedge clk);
    check("notmo.req", 32'(dmem_req), 32'd1);
    check("notmo.stall", 32'(stall), 32'd1);
    check_q("notmo.hold");
    dmem_ack = 1'b1; dmem_rdata = 32'hC0FFEE00;
    @(negedge clk);
    dmem_ack = 1'b0;
    exp_rd = 5'd8; exp_result = 32'hC0FFEE00; exp_regsrc = d_RegSrc; exp_itype = d_InstrType;
    exp_valid = 1'b1; exp_err = 1'b0;
    check_q("notmo.done");
`endif

    // Reset between edges mid-ACCESS
    run_op("pre_rst", 5'd10, 32'h0, 32'h0, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 0, 32'h0);
    en = 1'b1; d_rd = 5'd11; d_ALUresult = 32'h400; d_MemtoReg = 1'b1; d_MemWrite = 1'b0;
    d_MemAddrSrc = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("mid.req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("mid.req", 32'(dmem_req), 32'd0);
    check("mid.stall", 32'(stall), 32'd0);
    check("mid.addr", dmem_addr, 32'd0);
    check_q("mid");
    @(negedge clk);
    reset = 1'b1; en = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late_ack.req", 32'(dmem_req), 32'd0);
    check_q("late_ack");

    // Randomized traffic, including back-to-back memory ops
    for (int n = 0; n < 200; n++) begin
      a = $urandom; alu = $urandom; src = 1'($urandom);
      mtr = 1'($urandom); mw = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (src) a[1:0] = 2'b00;
        else     alu[1:0] = 2'b00;
      end
      run_op("rnd", 5'($urandom), a, $urandom, alu, mtr, 1'($urandom), mw, src, 3'($urandom),
             int'($urandom_range(0, 4)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (single clock, rising edge); reset input 1 (asynchronous, active-low, 0 = reset).
REQ-002 SHALL have: en input 1 (pipeline enable from hazard unit); d_rd input 5; d_A, d_B, d_ALUresult input 32 each; d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc input 1 each; d_InstrType input 3, all from EX/MEM register outputs.
REQ-003 SHALL have memory side: dmem_req output 1; dmem_we output 1; dmem_addr output 32; dmem_wdata output 32; dmem_rdata input 32; dmem_ack input 1.
REQ-004 SHALL have WB side: q_rd output 5; q_result output 32; q_RegSrc output 1; q_InstrType output 3; q_valid output 1; q_err output 1; stall output 1 (freezes EX/MEM and upstream).

Function
REQ-005 Memory op = d_MemtoReg (load) OR d_MemWrite (store); both set = store only, no readback.
REQ-006 Address = d_ALUresult when d_MemAddrSrc=0, d_A when 1; wdata = d_B.
REQ-007 FSM states IDLE, ACCESS; reset state IDLE.
REQ-008 IDLE, en=1, non-memory op: next edge q_result<=d_ALUresult, q_rd/q_RegSrc/q_InstrType<=inputs, q_valid<=1, q_err<=0; latency 1 cycle, stall=0.
REQ-009 IDLE, en=1, memory op, addr[1:0]=0: stall=1 combinationally; next edge latch addr/wdata/we/rd/ctrl, go ACCESS.
REQ-010 IDLE, en=1, memory op, addr[1:0]!=0: no request; next edge q_valid<=0, q_err<=1, q_result<=0, stall=0.
REQ-011 IDLE, en=0: all q_* hold, no request, stall=0.
REQ-012 ACCESS: dmem_req=1, dmem_we/addr/wdata from latched values, stable until ack; stall=1 while dmem_ack=0.
REQ-013 ACCESS with dmem_ack=1: stall=0 that cycle; next edge q_result<=dmem_rdata (load) or latched ALU result (store), q_valid<=1, q_err<=0, state IDLE.
REQ-014 ACCESS ignores en; access never aborted except by reset or timeout (REQ-020).
REQ-015 dmem_ack in IDLE SHALL be ignored.
REQ-016 Back-to-back memory ops: after ack edge, new op in IDLE starts next cycle; min 2 cycles per memory op with zero-wait ack.

Reset
REQ-017 reset=0 SHALL immediately (asynchronously) force state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, stall=0.
REQ-018 reset=0 SHALL clear q_rd=0, q_result=0, q_RegSrc=0, q_InstrType=0, q_valid=0, q_err=0, timeout counter=0.
REQ-019 Reset mid-ACCESS SHALL drop the transaction; late ack after release ignored per REQ-015.

Configuration
REQ-020 With MEM_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle without ack; at count 255 without ack, next edge drops req, q_valid<=0, q_err<=1, q_result<=0, state IDLE, stall=0 that cycle.
REQ-021 Without MEM_TIMEOUT_EN: no counter, ACCESS waits indefinitely, q_err set only by misalignment.

Verification
REQ-022 ALU op d_ALUresult=30, d_rd=2, en=1, no mem -> next edge q_result=30, q_rd=2, q_valid=1, stall=0, dmem_req never 1.
REQ-023 Load d_ALUresult=0x100, MemAddrSrc=0, ack 3 cycles after req, rdata=0xDEADBEEF -> dmem_addr=0x100, stall high 4 cycles, q_result=0xDEADBEEF after ack edge.
REQ-024 Store d_A=0x200, MemAddrSrc=1, d_B=25, zero-wait ack -> dmem_we=1, addr=0x200, wdata=25 for one cycle, q_valid=1.
REQ-025 Load with address 0x102 -> no dmem_req, q_err=1, q_valid=0, stall=0.
REQ-026 reset=0 asserted mid-ACCESS between edges -> dmem_req and stall fall immediately, all q_* = 0; ack after release ignored.
REQ-027 MEM_TIMEOUT_EN defined, ack never given -> req held 255 cycles, then q_err=1, state IDLE; undefined build -> req still high at cycle 300.
